// File: rtl/mlp_infer_ctrl.sv
// Sequencing controller for a combinational printed-MLP core: captures a sample,
// holds it for a settling window, then runs a one-compare-per-cycle argmax over the class scores.
module mlp_infer_ctrl #(
    parameter int IN_W    = 24,
    parameter int N_CLASS = 3,
    parameter int SCORE_W = 15,
    parameter int IDX_W   = 2,
    parameter int SETTLE  = 4,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [IN_W-1:0]            s_data,
    output logic [IN_W-1:0]            core_inp,
    input  logic [N_CLASS*SCORE_W-1:0] core_score,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [IDX_W-1:0]           m_class,
    output logic [SCORE_W-1:0]         m_score,
    output logic                       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SCAN   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int N_SLOT = 1 << IDX_W;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [IN_W-1:0]    core_inp_reg, core_inp_next;
    logic [SCORE_W-1:0] best_val_reg, best_val_next;
    logic [IDX_W-1:0]   best_idx_reg, best_idx_next;
    logic [IDX_W-1:0]   scan_idx_reg, scan_idx_next;
    logic [IDX_W-1:0]   m_class_reg, m_class_next;
    logic [SCORE_W-1:0] m_score_reg, m_score_next;

    // Index space is padded to a power of two so the scan mux never reads out of range.
    logic [SCORE_W-1:0] score_arr [N_SLOT];

    generate
        for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_score
            if (gi < N_CLASS) begin : g_live
                assign score_arr[gi] = core_score[gi*SCORE_W +: SCORE_W];
            end else begin : g_pad
                assign score_arr[gi] = '0;
            end
        end
    endgenerate

    logic [SCORE_W-1:0] sel_score;
    logic               cmp_gt;
    logic [SCORE_W-1:0] win_val;
    logic [IDX_W-1:0]   win_idx;
    logic               accept;

    // The single shared comparator; strict greater-than keeps ties on the lower index.
    assign sel_score = score_arr[scan_idx_reg];
    assign cmp_gt    = sel_score > best_val_reg;
    assign win_val   = cmp_gt ? sel_score : best_val_reg;
    assign win_idx   = cmp_gt ? scan_idx_reg : best_idx_reg;

    assign s_ready  = (state_reg == ST_IDLE) | ((state_reg == ST_DONE) & m_ready);
    assign accept   = s_valid & s_ready;
    assign m_valid  = (state_reg == ST_DONE);
    assign busy     = (state_reg == ST_SETTLE) | (state_reg == ST_SCAN);
    assign core_inp = core_inp_reg;
    assign m_class  = m_class_reg;
    assign m_score  = m_score_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            core_inp_reg <= '0;
            best_val_reg <= '0;
            best_idx_reg <= '0;
            scan_idx_reg <= '0;
            m_class_reg  <= '0;
            m_score_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            core_inp_reg <= core_inp_next;
            best_val_reg <= best_val_next;
            best_idx_reg <= best_idx_next;
            scan_idx_reg <= scan_idx_next;
            m_class_reg  <= m_class_next;
            m_score_reg  <= m_score_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        core_inp_next = core_inp_reg;
        best_val_next = best_val_reg;
        best_idx_next = best_idx_reg;
        scan_idx_next = scan_idx_reg;
        m_class_next  = m_class_reg;
        m_score_next  = m_score_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    core_inp_next = s_data;
                    cnt_next      = CNT_W'(SETTLE - 1);
                    state_next    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_reg == '0) begin
                    best_val_next = score_arr[0];
                    best_idx_next = '0;
                    scan_idx_next = IDX_W'(1);
                    state_next    = ST_SCAN;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_SCAN: begin
                best_val_next = win_val;
                best_idx_next = win_idx;
                scan_idx_next = scan_idx_reg + IDX_W'(1);
                if (scan_idx_reg == IDX_W'(N_CLASS - 1)) begin
                    m_class_next = win_idx;
                    m_score_next = win_val;
                    state_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                // Handoff and the next capture share this edge when both sides are ready.
                if (m_ready) begin
                    if (s_valid) begin
                        core_inp_next = s_data;
                        cnt_next      = CNT_W'(SETTLE - 1);
                        state_next    = ST_SETTLE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mlp_infer_ctrl.sv
// Self-checking bench for mlp_infer_ctrl: directed and randomized samples against a
// plain argmax reference with a fixed-latency expectation.
module tb_mlp_infer_ctrl;

    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic [23:0] core_inp;
    logic [44:0] core_score;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  m_class;
    logic [14:0] m_score;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    mlp_infer_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .core_inp   (core_inp),
        .core_score (core_score),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_class    (m_class),
        .m_score    (m_score),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Reference: highest score wins, first occurrence on ties.
    function automatic void ref_argmax(input logic [14:0] a, input logic [14:0] b,
                                       input logic [14:0] c, output int idx,
                                       output logic [14:0] val);
        logic [14:0] sc [3];
        sc[0] = a; sc[1] = b; sc[2] = c;
        val = sc[0];
        for (int k = 1; k < 3; k++) if (sc[k] > val) val = sc[k];
        idx = 0;
        for (int k = 2; k >= 0; k--) if (sc[k] == val) idx = k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (m_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        n_vec++;
        if (m_valid !== 1'b1) begin
            n_err++;
            $display("FAIL wait_valid: got m_valid=%b required 1 within 50 cycles", m_valid);
        end
    endtask

    task automatic accept(input logic [23:0] d, input logic [14:0] a,
                          input logic [14:0] b, input logic [14:0] c);
        int guard;
        s_data     = d;
        core_score = {c, b, a};
        s_valid    = 1'b1;
        guard      = 0;
        while (s_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic run_sample(input string tag, input logic [23:0] d, input logic [14:0] a,
                              input logic [14:0] b, input logic [14:0] c);
        int          lat;
        int          e_idx;
        logic [14:0] e_val;
        ref_argmax(a, b, c, e_idx, e_val);
        accept(d, a, b, c);
        if (core_inp !== d) begin n_err++; $display("FAIL %s core_inp: got %h required %h", tag, core_inp, d); end
        n_vec++;
        wait_valid(lat);
        if (lat !== LAT || m_class !== 2'(e_idx) || m_score !== e_val) begin
            n_err++;
            $display("FAIL %s result: got lat=%0d class=%0d score=%0d required lat=%0d class=%0d score=%0d",
                     tag, lat, m_class, m_score, LAT, e_idx, e_val);
        end
        n_vec++;
        $display("%s: in=%h scores=(%0d,%0d,%0d) class=%0d score=%0d lat=%0d",
                 tag, d, a, b, c, m_class, m_score, lat);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check({tag, " handoff m_valid"}, m_valid, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0; core_score = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset s_ready", s_ready, 1);
        check("reset m_valid", m_valid, 0);
        check("reset busy", busy, 0);
        check("reset m_class", m_class, 0);
        check("reset core_inp", core_inp, 0);
        $display("reset: s_ready=%b m_valid=%b busy=%b", s_ready, m_valid, busy);
    endtask

    task automatic test_single();
        bit busy_ok = 1'b1;
        accept(24'hABCDEF, 15'd100, 15'd2000, 15'd50);
        check("single core_inp", core_inp, 24'hABCDEF);
        for (int i = 0; i < LAT; i++) begin
            if (busy !== 1'b1 || m_valid !== 1'b0) busy_ok = 1'b0;
            tick();
        end
        check("single busy window", busy_ok, 1);
        check("single busy after", busy, 0);
        check("single m_valid", m_valid, 1);
        check("single m_class", m_class, 1);
        check("single m_score", m_score, 2000);
        $display("single: class=%0d score=%0d", m_class, m_score);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("single handoff", m_valid, 0);
    endtask

    task automatic test_ties();
        run_sample("tie_40_40_10", 24'h000001, 15'd40, 15'd40, 15'd10);
        run_sample("tie_5_9_9", 24'h000002, 15'd5, 15'd9, 15'd9);
        run_sample("all_zero", 24'h000003, 15'd0, 15'd0, 15'd0);
        run_sample("max_last", 24'h000004, 15'd1, 15'd2, 15'h7FFF);
    endtask

    task automatic test_backpressure();
        int          lat;
        bit          stable = 1'b1;
        logic [1:0]  h_class;
        logic [14:0] h_score;
        accept(24'h123456, 15'd7, 15'd3, 15'd900);
        wait_valid(lat);
        h_class = m_class;
        h_score = m_score;
        check("bp class", h_class, 2);
        check("bp score", h_score, 900);
        s_data  = 24'h654321;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_valid !== 1'b1 || m_class !== h_class || m_score !== h_score ||
                s_ready !== 1'b0 || core_inp !== 24'h123456) stable = 1'b0;
        end
        check("bp held stable", stable, 1);
        core_score = {15'd1, 15'd600, 15'd2};
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        s_valid = 1'b0;
        check("bp release m_valid", m_valid, 0);
        check("bp release core_inp", core_inp, 24'h654321);
        check("bp release busy", busy, 1);
        wait_valid(lat);
        check("bp second lat", lat, LAT);
        check("bp second class", m_class, 1);
        check("bp second score", m_score, 600);
        $display("backpressure: held class=%0d score=%0d, next class=%0d score=%0d",
                 h_class, h_score, m_class, m_score);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [14:0] sa [4];
        logic [14:0] sb [4];
        logic [14:0] sc [4];
        int          t_prev;
        int          lat;
        int          e_idx;
        logic [14:0] e_val;
        for (int i = 0; i < 4; i++) begin
            sa[i] = 15'($urandom_range(0, 32767));
            sb[i] = 15'($urandom_range(0, 32767));
            sc[i] = 15'($urandom_range(0, 32767));
        end
        m_ready    = 1'b1;
        s_data     = 24'($urandom);
        core_score = {sc[0], sb[0], sa[0]};
        s_valid    = 1'b1;
        tick();
        t_prev = cyc;
        for (int i = 0; i < 4; i++) begin
            wait_valid(lat);
            check("b2b spacing", lat, LAT);
            ref_argmax(sa[i], sb[i], sc[i], e_idx, e_val);
            check("b2b class", m_class, e_idx);
            check("b2b score", m_score, e_val);
            $display("b2b[%0d]: class=%0d score=%0d at cycle %0d (+%0d)",
                     i, m_class, m_score, cyc, cyc - t_prev);
            t_prev = cyc;
            if (i < 3) begin
                s_data     = 24'($urandom);
                core_score = {sc[i+1], sb[i+1], sa[i+1]};
            end else begin
                s_valid = 1'b0;
            end
            tick();
        end
        m_ready = 1'b0;
        check("b2b drained", m_valid, 0);
    endtask

    task automatic test_reset_mid_scan();
        bit saw_valid = 1'b0;
        run_sample("pre_abort", 24'h0A0A0A, 15'd1, 15'd2, 15'd3);
        accept(24'hFEDCBA, 15'd10, 15'd20, 15'd30);
        for (int i = 0; i < 5; i++) tick();
        check("mid busy before rst", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid rst m_valid", m_valid, 0);
        check("mid rst busy", busy, 0);
        check("mid rst core_inp", core_inp, 0);
        check("mid rst m_class", m_class, 0);
        check("mid rst m_score", m_score, 0);
        check("mid rst s_ready", s_ready, 1);
        $display("reset_mid_scan: core_inp=%h m_class=%0d busy=%b", core_inp, m_class, busy);
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_valid === 1'b1) saw_valid = 1'b1;
        end
        check("mid aborted no m_valid", saw_valid, 0);
        run_sample("post_abort", 24'h5A5A5A, 15'd300, 15'd299, 15'd301);
    endtask

    task automatic test_random();
        logic [14:0] a, b, c;
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = 15'($urandom_range(0, 3));
                b = 15'($urandom_range(0, 3));
                c = 15'($urandom_range(0, 3));
            end else begin
                a = 15'($urandom_range(0, 32767));
                b = 15'($urandom_range(0, 32767));
                c = 15'($urandom_range(0, 32767));
            end
            run_sample($sformatf("rand[%0d]", i), 24'($urandom), a, b, c);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ties();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
